// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of one 32-bit block each.
// Hits complete in the request cycle; misses stall the CPU until the line is refilled.
module data_cache (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_t;

   state_t      r_state;
   logic [7:0]  r_valid;
   logic [7:0]  r_dirty;
   logic [2:0]  r_tag  [8];
   logic [31:0] r_data [8];
   logic [31:0] r_fill;

   logic [2:0]  w_tag;
   logic [2:0]  w_index;
   logic [4:0]  w_bit;
   logic        w_req;
   logic        w_hit;

   assign w_tag   = ADDRESS[7:5];
   assign w_index = ADDRESS[4:2];
   assign w_bit   = {ADDRESS[1:0], 3'b000};
   assign w_req   = READ | WRITE;
   assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

   // Reset forces the CPU-facing outputs quiet regardless of state or request.
   always_comb begin
      BUSYWAIT = 1'b0;
      READDATA = 8'h00;
      if (RESET) begin
         if (r_state != StIdle) begin
            BUSYWAIT = 1'b1;
         end else if (w_req) begin
            if (w_hit) READDATA = r_data[w_index][w_bit +: 8];
            else       BUSYWAIT = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state       <= StIdle;
         r_valid       <= '0;
         r_dirty       <= '0;
         MEM_READ      <= 1'b0;
         MEM_WRITE     <= 1'b0;
         MEM_ADDRESS   <= '0;
         MEM_WRITEDATA <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_req) begin
                  if (w_hit) begin
                     // WRITE wins when both READ and WRITE are high.
                     if (WRITE) begin
                        r_data[w_index][w_bit +: 8] <= WRITEDATA;
                        r_dirty[w_index]            <= 1'b1;
                     end
                  end else if (r_valid[w_index] && r_dirty[w_index]) begin
                     r_state       <= StWriteback;
                     MEM_WRITE     <= 1'b1;
                     MEM_ADDRESS   <= {r_tag[w_index], w_index};
                     MEM_WRITEDATA <= r_data[w_index];
                  end else begin
                     r_state     <= StFetch;
                     MEM_READ    <= 1'b1;
                     MEM_ADDRESS <= ADDRESS[7:2];
                  end
               end
            end
            StWriteback: begin
               // Hand straight over to the fetch so the two requests are back to back.
               if (!MEM_BUSYWAIT) begin
                  r_state     <= StFetch;
                  MEM_WRITE   <= 1'b0;
                  MEM_READ    <= 1'b1;
                  MEM_ADDRESS <= ADDRESS[7:2];
               end
            end
            StFetch: begin
               if (!MEM_BUSYWAIT) begin
                  r_state  <= StUpdate;
                  MEM_READ <= 1'b0;
                  r_fill   <= MEM_READDATA;
               end
            end
            StUpdate: begin
               r_state          <= StIdle;
               r_data[w_index]  <= r_fill;
               r_tag[w_index]   <= w_tag;
               r_valid[w_index] <= 1'b1;
               r_dirty[w_index] <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized traffic checked
// against a line-level cache model and a shadow of the backing memory.
module tb_data_cache;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   data_cache dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 5;

   function automatic logic [31:0] seed_word(input int i);
      if (i == 9) return 32'hDDCCBBAA;
      return 32'(i) * 32'h9E3779B1 + 32'h12345678;
   endfunction

   // Backing memory: request is busy for lat cycles, completes on the next.
   logic [31:0] mem [64];
   bit          mem_ready = 1'b0;
   int          cnt = 0;

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < lat);
   assign MEM_READDATA = mem[MEM_ADDRESS];

   always @(posedge CLK) begin
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
         mem_ready <= 1'b1;
      end
      if ((MEM_READ || MEM_WRITE) && cnt < lat) begin
         cnt <= cnt + 1;
      end else begin
         if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
         cnt <= 0;
      end
   end

   // Reference model: cache lines plus what memory must contain.
   logic        mv [8];
   logic        md [8];
   logic [2:0]  mt [8];
   logic [31:0] mdata [8];
   logic [31:0] model_mem [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
   endtask

   // One CPU access, started #1 after a posedge; checks every cycle until BUSYWAIT drops.
   task automatic access(input logic wr, input logic rd, input logic [7:0] a,
                         input logic [7:0] wd, output int ob, output logic [7:0] ord,
                         output logic [5:0] owa, output logic [31:0] owd,
                         output logic [5:0] ofa);
      logic [2:0]  idx;
      logic [2:0]  tg;
      logic [1:0]  off;
      logic        hit;
      logic        dwb;
      logic [5:0]  wba;
      logic [31:0] wbd;
      logic [7:0]  erd;
      int          nb;
      int          f0;
      bit          done;
      logic        wbp;
      logic        fp;
      idx = a[4:2];
      tg  = a[7:5];
      off = a[1:0];
      hit = mv[idx] && (mt[idx] == tg);
      dwb = !hit && mv[idx] && md[idx];
      nb  = hit ? 0 : (dwb ? 2 * lat + 4 : lat + 3);
      f0  = dwb ? lat + 2 : 1;
      wba = {mt[idx], idx};
      wbd = mdata[idx];
      if (!hit) begin
         if (dwb) model_mem[wba] = wbd;
         mdata[idx] = model_mem[a[7:2]];
         mt[idx]    = tg;
         mv[idx]    = 1'b1;
         md[idx]    = 1'b0;
      end
      erd = mdata[idx][8*off +: 8];
      if (wr) begin
         mdata[idx][8*off +: 8] = wd;
         md[idx] = 1'b1;
      end
      READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
      ob = 0; ord = 8'h00; owa = 6'h00; owd = 32'h0; ofa = 6'h00;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge CLK);
         wbp = dwb && c >= 1 && c <= lat + 1;
         fp  = !hit && c >= f0 && c <= f0 + lat;
         chk("busywait", 32'(BUSYWAIT), 32'(c < nb));
         chk("mem_write", 32'(MEM_WRITE), 32'(wbp));
         chk("mem_read", 32'(MEM_READ), 32'(fp));
         if (MEM_WRITE) begin
            owa = MEM_ADDRESS;
            owd = MEM_WRITEDATA;
            chk("wb_address", 32'(MEM_ADDRESS), 32'(wba));
            chk("wb_data", MEM_WRITEDATA, wbd);
         end
         if (MEM_READ) begin
            ofa = MEM_ADDRESS;
            chk("fetch_address", 32'(MEM_ADDRESS), 32'(a[7:2]));
         end
         if (BUSYWAIT) ob++;
         else begin
            ord  = READDATA;
            chk("readdata", 32'(READDATA), 32'(erd));
            done = 1'b1;
         end
      end
      if (!done) chk("access_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      READ = 1'b0;
      WRITE = 1'b0;
   endtask

   int          ob;
   logic [7:0]  ord;
   logic [5:0]  owa;
   logic [5:0]  ofa;
   logic [31:0] owd;
   logic [31:0] tmp;

   initial begin
      for (int i = 0; i < 64; i++) model_mem[i] = seed_word(i);
      model_reset();
      RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25; WRITEDATA = 8'h00;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
      chk("rst_readdata", 32'(READDATA), 32'd0);
      chk("rst_mem_read", 32'(MEM_READ), 32'd0);
      chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
      chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
      chk("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
      READ = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      lat = 5;
      access(1'b0, 1'b1, 8'h25, 8'h00, ob, ord, owa, owd, ofa);
      chk("cold_busy_cycles", 32'(ob), 32'd8);
      chk("cold_fetch_addr", 32'(ofa), 32'h09);
      chk("cold_readdata", 32'(ord), 32'hBB);
      access(1'b0, 1'b1, 8'h27, 8'h00, ob, ord, owa, owd, ofa);
      chk("hit_busy_cycles", 32'(ob), 32'd0);
      chk("hit_readdata", 32'(ord), 32'hDD);
      access(1'b1, 1'b0, 8'h24, 8'h11, ob, ord, owa, owd, ofa);
      chk("whit_busy_cycles", 32'(ob), 32'd0);
      access(1'b0, 1'b1, 8'h44, 8'h00, ob, ord, owa, owd, ofa);
      chk("evict_busy_cycles", 32'(ob), 32'd14);
      chk("evict_wb_addr", 32'(owa), 32'h09);
      chk("evict_wb_data", owd, 32'hDDCCBB11);
      chk("evict_fetch_addr", 32'(ofa), 32'h11);
      access(1'b1, 1'b0, 8'h83, 8'h5A, ob, ord, owa, owd, ofa);
      chk("walloc_fetch_addr", 32'(ofa), 32'h20);
      access(1'b0, 1'b1, 8'h83, 8'h00, ob, ord, owa, owd, ofa);
      chk("walloc_readback", 32'(ord), 32'h5A);
      access(1'b1, 1'b1, 8'h83, 8'h77, ob, ord, owa, owd, ofa);
      chk("both_busy_cycles", 32'(ob), 32'd0);
      access(1'b0, 1'b1, 8'h83, 8'h00, ob, ord, owa, owd, ofa);
      chk("both_readback", 32'(ord), 32'h77);
      access(1'b0, 1'b1, 8'hA3, 8'h00, ob, ord, owa, owd, ofa);
      chk("both_dirty_wb_addr", 32'(owa), 32'h20);

      // Reset in the middle of a fetch; the dirty line at index 1 must be dropped.
      access(1'b1, 1'b0, 8'h45, 8'h99, ob, ord, owa, owd, ofa);
      READ = 1'b1; ADDRESS = 8'h08;
      @(negedge CLK);
      chk("mid_detect_busy", 32'(BUSYWAIT), 32'd1);
      @(negedge CLK);
      chk("mid_fetch_read", 32'(MEM_READ), 32'd1);
      chk("mid_fetch_addr", 32'(MEM_ADDRESS), 32'h02);
      RESET = 1'b0; READ = 1'b0;
      @(negedge CLK);
      chk("mid_rst_mem_read", 32'(MEM_READ), 32'd0);
      chk("mid_rst_mem_write", 32'(MEM_WRITE), 32'd0);
      chk("mid_rst_busywait", 32'(BUSYWAIT), 32'd0);
      chk("mid_rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
      RESET = 1'b1;
      model_reset();
      @(posedge CLK);
      #1;
      access(1'b0, 1'b1, 8'h45, 8'h00, ob, ord, owa, owd, ofa);
      chk("reread_busy_cycles", 32'(ob), 32'd8);
      tmp = seed_word(6'h11);
      chk("reread_discarded", 32'(ord), 32'(tmp[15:8]));

      for (int n = 0; n < 300; n++) begin
         logic [7:0] a;
         int         op;
         lat = $urandom_range(0, 3);
         a   = {3'($urandom_range(0, 2)), 5'($urandom)};
         op  = $urandom_range(0, 2);
         access(op != 0, op != 1, a, 8'($urandom), ob, ord, owa, owd, ofa);
      end

      for (int i = 0; i < 64; i++) chk("final_memory", mem[i], model_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
